// File: rtl/gestor_alarma_if.sv
`default_nettype none
// ============================================================================
// gestor_alarma_if : sensor flags and ack in, alarm state/indicators out
// Rev 1.0
// ============================================================================
interface gestor_alarma_if #(
  parameter int CNT_W = 8
);
  logic             persistencia;
  logic             fuera_rango;
  logic             ack;
  logic [1:0]       estado;
  logic             alarma;
  logic             pendiente;
  logic             led;
  logic             irq;
  logic [CNT_W-1:0] eventos;

  modport master (
    output persistencia, fuera_rango, ack,
    input  estado, alarma, pendiente, led, irq, eventos
  );

  modport slave (
    input  persistencia, fuera_rango, ack,
    output estado, alarma, pendiente, led, irq, eventos
  );
endinterface
`default_nettype wire

// File: rtl/gestor_alarma.sv
`default_nettype none
// ============================================================================
// gestor_alarma : latched alarm with recovery hysteresis, ack, blinking LED,
// entry irq and saturating event count. Define AUTO_ACK_EN to skip ESPERA_ACK.
// Rev 1.0
// ============================================================================
module gestor_alarma #(
  parameter int T_RECUP  = 8,
  parameter int PARPADEO = 4,
  parameter int CNT_W    = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  gestor_alarma_if.slave   bus
);

  typedef enum logic [1:0] {
    S_NORMAL       = 2'b00,
    S_ALARMA       = 2'b01,
    S_RECUPERACION = 2'b10,
    S_ESPERA_ACK   = 2'b11
  } estado_t;

  localparam logic [7:0]       c_rec_fin  = 8'(T_RECUP - 1);
  localparam logic [7:0]       c_parp_fin = 8'(PARPADEO - 1);
  localparam logic [CNT_W-1:0] c_uno      = {{(CNT_W-1){1'b0}}, 1'b1};

  estado_t          r_estado;
  logic [7:0]       r_cnt_rec;
  logic [7:0]       r_cnt_parp;
  logic             r_fase;
  logic             r_led;
  logic             r_irq;
  logic [CNT_W-1:0] r_eventos;
  logic [CNT_W-1:0] w_eventos_inc;

  assign w_eventos_inc = (&r_eventos) ? r_eventos : r_eventos + c_uno;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= S_NORMAL;
      r_cnt_rec  <= 8'd0;
      r_cnt_parp <= 8'd0;
      r_fase     <= 1'b1;
      r_led      <= 1'b0;
      r_irq      <= 1'b0;
      r_eventos  <= '0;
    end else begin
      r_irq <= 1'b0;
      case (r_estado)
        S_NORMAL: begin
          if (bus.persistencia) begin
            r_estado   <= S_ALARMA;
            r_irq      <= 1'b1;
            r_eventos  <= w_eventos_inc;
            r_cnt_parp <= 8'd0;
            r_fase     <= 1'b1;
            r_led      <= 1'b1;
          end else begin
            r_led <= 1'b0;
          end
        end
        S_ALARMA: begin
          if (!bus.fuera_rango) begin
            r_estado   <= S_RECUPERACION;
            r_cnt_rec  <= 8'd0;
            r_cnt_parp <= 8'd0;
            r_fase     <= 1'b1;
            r_led      <= 1'b1;
          end else if (r_cnt_parp == c_parp_fin) begin
            // Half-period boundary: led follows the toggled phase immediately
            r_cnt_parp <= 8'd0;
            r_fase     <= ~r_fase;
            r_led      <= ~r_fase;
          end else begin
            r_cnt_parp <= r_cnt_parp + 8'd1;
            r_led      <= r_fase;
          end
        end
        S_RECUPERACION: begin
          if (bus.fuera_rango) begin
            // Relapse is not a new event: no irq, no count
            r_estado   <= S_ALARMA;
            r_cnt_parp <= 8'd0;
            r_fase     <= 1'b1;
            r_led      <= 1'b1;
          end else if (r_cnt_rec == c_rec_fin) begin
`ifdef AUTO_ACK_EN
            r_estado <= S_NORMAL;
            r_led    <= 1'b0;
`else
            r_estado <= S_ESPERA_ACK;
            r_led    <= 1'b1;
`endif
          end else begin
            r_cnt_rec <= r_cnt_rec + 8'd1;
            r_led     <= 1'b1;
          end
        end
        default: begin
`ifdef AUTO_ACK_EN
          r_estado <= S_NORMAL;
          r_led    <= 1'b0;
`else
          if (bus.persistencia) begin
            r_estado   <= S_ALARMA;
            r_irq      <= 1'b1;
            r_eventos  <= w_eventos_inc;
            r_cnt_parp <= 8'd0;
            r_fase     <= 1'b1;
            r_led      <= 1'b1;
          end else if (bus.ack) begin
            r_estado <= S_NORMAL;
            r_led    <= 1'b0;
          end else begin
            r_led <= 1'b1;
          end
`endif
        end
      endcase
    end
  end

  assign bus.estado  = r_estado;
  assign bus.alarma  = (r_estado == S_ALARMA) || (r_estado == S_RECUPERACION);
`ifdef AUTO_ACK_EN
  assign bus.pendiente = 1'b0;
`else
  assign bus.pendiente = (r_estado == S_ESPERA_ACK);
`endif
  assign bus.led     = r_led;
  assign bus.irq     = r_irq;
  assign bus.eventos = r_eventos;

endmodule
`default_nettype wire

// File: tb/tb_gestor_alarma.sv
`default_nettype none
// ============================================================================
// tb_gestor_alarma : directed + random stimulus against a reference model,
// expected outputs queued per cycle and checked by an independent monitor.
// Rev 1.0
// ============================================================================
module tb_gestor_alarma;

  localparam int T_RECUP  = 8;
  localparam int PARPADEO = 4;
  localparam int CNT_W    = 8;
  localparam int EV_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0]       estado;
    logic             alarma;
    logic             pendiente;
    logic             led;
    logic             irq;
    logic [CNT_W-1:0] eventos;
  } salida_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gestor_alarma_if #(.CNT_W(CNT_W)) bus ();

  gestor_alarma #(
    .T_RECUP (T_RECUP),
    .PARPADEO(PARPADEO),
    .CNT_W   (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  salida_t esperado_q[$];
  int      n_tests  = 0;
  int      n_fallos = 0;
  int      ciclo    = 0;

  // Reference model: state as plain ints, led derived from time spent in ALARMA
  int m_st    = 0;
  int m_clean = 0;
  int m_k     = 0;
  int m_ev    = 0;
  int m_irq   = 0;

  task automatic modelo_evento();
    m_st  = 1;
    m_k   = 0;
    m_irq = 1;
    m_ev  = (m_ev < EV_MAX) ? m_ev + 1 : EV_MAX;
  endtask

  task automatic modelo_paso(input bit r, input bit p, input bit fr, input bit a);
    m_irq = 0;
    if (r) begin
      m_st = 0; m_clean = 0; m_k = 0; m_ev = 0;
    end else begin
      case (m_st)
        0: if (p) modelo_evento();
        1: if (!fr) begin m_st = 2; m_clean = 0; end
           else m_k++;
        2: if (fr) begin m_st = 1; m_k = 0; end
           else begin
             m_clean++;
`ifdef AUTO_ACK_EN
             if (m_clean == T_RECUP) m_st = 0;
`else
             if (m_clean == T_RECUP) m_st = 3;
`endif
           end
        default: if (p) modelo_evento();
                 else if (a) m_st = 0;
      endcase
    end
  endtask

  function automatic salida_t modelo_salida();
    salida_t s;
    s.estado    = 2'(m_st);
    s.alarma    = (m_st == 1) || (m_st == 2);
    s.pendiente = (m_st == 3);
    s.led       = (m_st == 1) ? (((m_k / PARPADEO) % 2) == 0) : (m_st != 0);
    s.irq       = (m_irq != 0);
    s.eventos   = CNT_W'(m_ev);
    return s;
  endfunction

  task automatic ciclo_tb(input bit r, input bit p, input bit fr, input bit a);
    @(negedge clk);
    rst              = r;
    bus.persistencia = p;
    bus.fuera_rango  = fr;
    bus.ack          = a;
    modelo_paso(r, p, fr, a);
    esperado_q.push_back(modelo_salida());
  endtask

  task automatic comparar(input string nombre, input int real_v, input int esp_v);
    n_tests++;
    if (real_v != esp_v) begin
      n_fallos++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nombre, ciclo, real_v, esp_v);
    end
  endtask

  initial begin : monitor
    salida_t e;
    forever begin
      @(posedge clk);
      #1;
      ciclo++;
      if (esperado_q.size() > 0) begin
        e = esperado_q.pop_front();
        comparar("estado",    int'(bus.estado),    int'(e.estado));
        comparar("alarma",    int'(bus.alarma),    int'(e.alarma));
        comparar("pendiente", int'(bus.pendiente), int'(e.pendiente));
        comparar("led",       int'(bus.led),       int'(e.led));
        comparar("irq",       int'(bus.irq),       int'(e.irq));
        comparar("eventos",   int'(bus.eventos),   int'(e.eventos));
      end
    end
  end

  initial begin : estimulo
    bus.persistencia = 1'b0;
    bus.fuera_rango  = 1'b0;
    bus.ack          = 1'b0;

    repeat (2) ciclo_tb(1, 0, 0, 0);
    ciclo_tb(0, 1, 1, 0);                        // NORMAL -> ALARMA event
    repeat (16) ciclo_tb(0, 0, 1, 0);            // blink pattern
    repeat (1 + T_RECUP) ciclo_tb(0, 0, 0, 0);   // recovery to ESPERA_ACK
    repeat (2) ciclo_tb(0, 0, 0, 0);
    ciclo_tb(0, 0, 0, 1);                        // ack -> NORMAL
    ciclo_tb(0, 0, 1, 1);                        // fuera_rango/ack alone do nothing
    ciclo_tb(0, 1, 1, 1);                        // persistencia beats ack
    repeat (1 + 5) ciclo_tb(0, 0, 0, 0);
    ciclo_tb(0, 0, 1, 0);                        // relapse, no irq
    repeat (3) ciclo_tb(0, 0, 1, 0);
    repeat (1 + T_RECUP) ciclo_tb(0, 1, 0, 1);   // persistencia w/o fuera_rango
    ciclo_tb(0, 1, 0, 1);                        // ESPERA_ACK: persistencia + ack
    ciclo_tb(0, 0, 1, 0);

    // Saturation: repeated event entries from ESPERA_ACK
    for (int i = 0; i < 260; i++) begin
      ciclo_tb(0, 1, 1, 0);
      repeat (1 + T_RECUP) ciclo_tb(0, 0, 0, 0);
    end
    ciclo_tb(0, 0, 0, 1);

    // Reset mid-recovery
    ciclo_tb(0, 1, 1, 0);
    repeat (3) ciclo_tb(0, 0, 0, 0);
    ciclo_tb(1, 1, 1, 1);
    ciclo_tb(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      ciclo_tb(($urandom % 300) == 0,
               ($urandom % 10) == 0,
               ($urandom % 8) == 0,
               ($urandom % 4) == 0);
    end

    repeat (3) @(negedge clk);
    comparar("cola_vacia", esperado_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fallos);
    $finish;
  end

endmodule
`default_nettype wire
